// File: rtl/palette_arb_pkg.sv
// palette_arb_pkg: shared FSM state type and default widths for the palette RAM arbiter
package palette_arb_pkg;
  localparam int AW_DEF = 11;
  localparam int DW_DEF = 16;
  typedef enum logic [1:0] {IDLE, CPU_ACC, CPU_CAP, CPU_REL} arb_state_t;
endpackage

// File: rtl/palette_ram_arbiter.sv
// palette_ram_arbiter: shares one synchronous palette RAM between a fixed-latency video read path and CPU accesses
module palette_ram_arbiter
  import palette_arb_pkg::*;
#(
  parameter int AW = AW_DEF,
  parameter int DW = DW_DEF,
  parameter bit BLANK_ONLY_WR = 1'b1
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          pix_ce,
  input  logic [AW-1:0] vid_addr,
  input  logic          hblank,
  input  logic          vblank,
  output logic [DW-1:0] vid_data,
  output logic          vid_valid,
  input  logic          cpu_req,
  input  logic          cpu_we,
  input  logic [AW-1:0] cpu_addr,
  input  logic [DW-1:0] cpu_wdata,
  output logic [DW-1:0] cpu_rdata,
  output logic          cpu_ack,
  output logic [AW-1:0] ram_addr,
  output logic          ram_we,
  output logic [DW-1:0] ram_wdata,
  input  logic [DW-1:0] ram_rdata
);
  logic [1:0]    r_rst_sync;
  logic          w_rst_n;
  arb_state_t    r_state, w_next;
  logic          w_grant;
  logic [2:0]    r_vpipe;
  logic [DW-1:0] r_vid_data, r_cpu_rdata, r_ram_wdata;
  logic [AW-1:0] r_ram_addr;
  logic          r_ram_we;
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) r_rst_sync <= '0;
    else r_rst_sync <= {r_rst_sync[0], 1'b1};
  assign w_rst_n = r_rst_sync[1];
  // A strobe this cycle claims the next cycle for video, so the CPU must wait.
  always_comb begin
    w_grant = r_state == IDLE && cpu_req && !pix_ce && (!cpu_we || !BLANK_ONLY_WR || hblank || vblank);
    w_next = w_grant ? CPU_ACC :
             r_state == CPU_ACC ? CPU_CAP :
             r_state == CPU_CAP ? CPU_REL :
             (r_state == CPU_REL && !cpu_req) ? IDLE : r_state;
  end
  always_ff @(posedge clk or negedge w_rst_n)
    if (!w_rst_n) r_state <= IDLE;
    else r_state <= w_next;
  // RAM port registers are loaded one edge ahead so they are stable for the whole slot.
  always_ff @(posedge clk or negedge w_rst_n)
    if (!w_rst_n) begin
      r_vpipe     <= '0;
      r_vid_data  <= '0;
      r_cpu_rdata <= '0;
      r_ram_addr  <= '0;
      r_ram_wdata <= '0;
      r_ram_we    <= 1'b0;
    end else begin
      r_vpipe  <= {r_vpipe[1:0], pix_ce};
      r_ram_we <= w_grant && cpu_we;
      if (pix_ce) r_ram_addr <= vid_addr;
      else if (w_grant) begin
        r_ram_addr  <= cpu_addr;
        r_ram_wdata <= cpu_wdata;
      end
      if (r_vpipe[1]) r_vid_data <= ram_rdata;
      if (r_state == CPU_CAP && !cpu_we) r_cpu_rdata <= ram_rdata;
    end
  assign vid_data  = r_vid_data;
  assign vid_valid = r_vpipe[2];
  assign cpu_ack   = r_state == CPU_CAP;
  assign cpu_rdata = (cpu_ack && !cpu_we) ? ram_rdata : r_cpu_rdata;
  assign ram_addr  = r_ram_addr;
  assign ram_we    = r_ram_we;
  assign ram_wdata = r_ram_wdata;
endmodule
